// File: rtl/clear_arb_pipeline.sv
// Viewport clear generator feeding a fixed-priority pixel arbiter
// (clear > raster > simd). The arbiter is combinational, so it adds no latency.
module clear_arb_pipeline (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        done,
    input  logic [31:0] color,
    input  logic [31:0] xmin,
    input  logic [31:0] ymin,
    input  logic [31:0] xmax,
    input  logic [31:0] ymax,
    input  logic        raster_valid,
    input  logic [31:0] raster_x,
    input  logic [31:0] raster_y,
    input  logic [31:0] raster_color,
    input  logic        simd_valid,
    input  logic [31:0] simd_x,
    input  logic [31:0] simd_y,
    input  logic [31:0] simd_color,
    output logic        pixel_valid,
    output logic [31:0] pixel_x,
    output logic [31:0] pixel_y,
    output logic [31:0] pixel_color
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        clear_valid_q, clear_valid_d;
    logic        done_q, done_d;
    logic [31:0] clear_x_q, clear_x_d;
    logic [31:0] clear_y_q, clear_y_d;
    logic [31:0] color_q, color_d;
    logic [31:0] xmin_q, xmin_d;
    logic [31:0] xmax_q, xmax_d;
    logic [31:0] ymax_q, ymax_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            clear_valid_q <= 1'b0;
            done_q        <= 1'b0;
            clear_x_q     <= '0;
            clear_y_q     <= '0;
            color_q       <= '0;
            xmin_q        <= '0;
            xmax_q        <= '0;
            ymax_q        <= '0;
        end else begin
            state_q       <= state_d;
            clear_valid_q <= clear_valid_d;
            done_q        <= done_d;
            clear_x_q     <= clear_x_d;
            clear_y_q     <= clear_y_d;
            color_q       <= color_d;
            xmin_q        <= xmin_d;
            xmax_q        <= xmax_d;
            ymax_q        <= ymax_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        clear_valid_d = clear_valid_q;
        done_d        = 1'b0;
        clear_x_d     = clear_x_q;
        clear_y_d     = clear_y_q;
        color_d       = color_q;
        xmin_d        = xmin_q;
        xmax_d        = xmax_q;
        ymax_d        = ymax_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    color_d = color;
                    xmin_d  = xmin;
                    xmax_d  = xmax;
                    ymax_d  = ymax;
                    // The y counter doubles as the ymin latch: it starts there.
                    clear_x_d = xmin;
                    clear_y_d = ymin;
                    if ((xmax < xmin) || (ymax < ymin)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d       = BUSY;
                        clear_valid_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                // Compare before incrementing so all-ones bounds never wrap.
                if (clear_x_q == xmax_q) begin
                    if (clear_y_q == ymax_q) begin
                        state_d       = IDLE;
                        clear_valid_d = 1'b0;
                        done_d        = 1'b1;
                    end else begin
                        clear_x_d = xmin_q;
                        clear_y_d = clear_y_q + 32'd1;
                    end
                end else begin
                    clear_x_d = clear_x_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign done = done_q;

    always_comb begin
        pixel_valid = 1'b0;
        pixel_x     = '0;
        pixel_y     = '0;
        pixel_color = '0;
        if (clear_valid_q) begin
            pixel_valid = 1'b1;
            pixel_x     = clear_x_q;
            pixel_y     = clear_y_q;
            pixel_color = color_q;
        end else if (raster_valid) begin
            pixel_valid = 1'b1;
            pixel_x     = raster_x;
            pixel_y     = raster_y;
            pixel_color = raster_color;
        end else if (simd_valid) begin
            pixel_valid = 1'b1;
            pixel_x     = simd_x;
            pixel_y     = simd_y;
            pixel_color = simd_color;
        end
    end

endmodule

// File: tb/tb_clear_arb_pipeline.sv
// Directed bench for clear_arb_pipeline: clear scan order, done timing,
// arbiter priority, all-ones bounds and reset abort.
module tb_clear_arb_pipeline;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        done;
    logic [31:0] color, xmin, ymin, xmax, ymax;
    logic        raster_valid, simd_valid;
    logic [31:0] raster_x, raster_y, raster_color;
    logic [31:0] simd_x, simd_y, simd_color;
    logic        pixel_valid;
    logic [31:0] pixel_x, pixel_y, pixel_color;

    int checks = 0;
    int errors = 0;

    clear_arb_pipeline dut (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done),
        .color(color), .xmin(xmin), .ymin(ymin), .xmax(xmax), .ymax(ymax),
        .raster_valid(raster_valid), .raster_x(raster_x), .raster_y(raster_y),
        .raster_color(raster_color),
        .simd_valid(simd_valid), .simd_x(simd_x), .simd_y(simd_y),
        .simd_color(simd_color),
        .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_color(pixel_color)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_pix(input string tag, input logic v, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] c, input logic d);
        chk({tag, "_valid"}, {31'd0, pixel_valid}, {31'd0, v});
        chk({tag, "_x"}, pixel_x, x);
        chk({tag, "_y"}, pixel_y, y);
        chk({tag, "_color"}, pixel_color, c);
        chk({tag, "_done"}, {31'd0, done}, {31'd0, d});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0;
        color = '0; xmin = '0; ymin = '0; xmax = '0; ymax = '0;
        raster_valid = 1'b1; raster_x = 32'd7; raster_y = 32'd8; raster_color = 32'h1111_1111;
        simd_valid = 1'b0; simd_x = 32'd9; simd_y = 32'd9; simd_color = 32'h2222_2222;

        // Reset: arbiter still passes raster through, clear path silent
        #12;
        chk_pix("rst_raster", 1'b1, 32'd7, 32'd8, 32'h1111_1111, 1'b0);
        raster_valid = 1'b0;
        #1;
        chk_pix("rst_none", 1'b0, '0, '0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk_pix("idle", 1'b0, '0, '0, '0, 1'b0);

        // Basic clear (2,3)-(4,4) with raster and simd contending, extra start while busy
        xmin = 32'd2; ymin = 32'd3; xmax = 32'd4; ymax = 32'd4; color = 32'hFF00_FF00;
        raster_valid = 1'b1; simd_valid = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        xmin = '0; ymin = '0; xmax = '0; ymax = '0; color = '0;
        for (int i = 0; i < 6; i++) begin
            chk_pix($sformatf("basic_p%0d", i), 1'b1, 32'(2 + i % 3), 32'(3 + i / 3),
                    32'hFF00_FF00, 1'b0);
            if (i == 2) begin
                start = 1'b1; xmin = 32'd0; xmax = 32'd9; ymax = 32'd9; color = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            tick;
        end
        start = 1'b0;
        chk_pix("basic_done_raster", 1'b1, 32'd7, 32'd8, 32'h1111_1111, 1'b1);
        raster_valid = 1'b0;
        #1;
        chk_pix("prio_simd", 1'b1, 32'd9, 32'd9, 32'h2222_2222, 1'b1);
        simd_valid = 1'b0;
        #1;
        chk_pix("prio_none", 1'b0, '0, '0, '0, 1'b1);
        tick;
        chk_pix("basic_after", 1'b0, '0, '0, '0, 1'b0);

        // Zero bounds: single pixel, then empty-viewport start in the done cycle
        xmin = '0; ymin = '0; xmax = '0; ymax = '0; color = 32'h1234_5678;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk_pix("zero_p0", 1'b1, '0, '0, 32'h1234_5678, 1'b0);
        tick;
        chk_pix("zero_done", 1'b0, '0, '0, '0, 1'b1);
        xmin = 32'd5; xmax = 32'd4; start = 1'b1;
        tick;
        start = 1'b0;
        chk_pix("empty_done", 1'b0, '0, '0, '0, 1'b1);
        tick;
        chk_pix("empty_after", 1'b0, '0, '0, '0, 1'b0);

        // All-ones bounds must terminate after two pixels
        xmin = 32'hFFFF_FFFE; xmax = 32'hFFFF_FFFF; ymin = 32'hFFFF_FFFF; ymax = 32'hFFFF_FFFF;
        color = 32'hCAFE_0001; start = 1'b1;
        tick;
        start = 1'b0;
        chk_pix("max_p0", 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hCAFE_0001, 1'b0);
        tick;
        chk_pix("max_p1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hCAFE_0001, 1'b0);
        tick;
        chk_pix("max_done", 1'b0, '0, '0, '0, 1'b1);
        tick;
        chk_pix("max_after", 1'b0, '0, '0, '0, 1'b0);

        // Reset mid-clear aborts with no done; idle until next start
        xmin = '0; ymin = '0; xmax = 32'd3; ymax = 32'd3; color = 32'h0000_00AB;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk_pix("abort_p0", 1'b1, '0, '0, 32'h0000_00AB, 1'b0);
        tick;
        chk_pix("abort_p1", 1'b1, 32'd1, '0, 32'h0000_00AB, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_pix("abort_rst", 1'b0, '0, '0, '0, 1'b0);
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk_pix($sformatf("abort_idle%0d", i), 1'b0, '0, '0, '0, 1'b0);
            tick;
        end
        xmin = 32'd1; ymin = 32'd1; xmax = 32'd1; ymax = 32'd1; color = 32'h0000_00CD;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk_pix("restart_p0", 1'b1, 32'd1, 32'd1, 32'h0000_00CD, 1'b0);
        tick;
        chk_pix("restart_done", 1'b0, '0, '0, '0, 1'b1);
        tick;
        chk_pix("restart_after", 1'b0, '0, '0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clear_arb_pipeline.md
CLEAR_ARB_PIPELINE -- requirements
Module: clear_arb_pipeline

Interface
REQ-001 Parameters: none; all coordinate and colour buses SHALL be 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  one-cycle request to begin a clear.
REQ-005 done  output  1  one-cycle pulse when the clear completes.
REQ-006 color  input  32  fill colour.
REQ-007 xmin, ymin, xmax, ymax  input  32 each  inclusive viewport bounds, unsigned.
REQ-008 raster_valid  input  1, and raster_x, raster_y, raster_color  input  32 each  raster pixel source.
REQ-009 simd_valid  input  1, and simd_x, simd_y, simd_color  input  32 each  SIMD pixel source.
REQ-010 pixel_valid  output  1, and pixel_x, pixel_y, pixel_color  output  32 each  arbitrated pixel write.

Function
REQ-011 The block SHALL contain a clear generator with two states, IDLE and BUSY.
REQ-012 Start handling: start=1 in IDLE SHALL latch color and all four bounds, and the generator SHALL enter BUSY on the same edge.
REQ-013 Empty viewport (xmax<xmin or ymax<ymin, unsigned): the generator SHALL emit no pixels, pulse done in the cycle after start, and stay IDLE.
REQ-014 Start while BUSY SHALL be ignored; bound and colour inputs SHALL be ignored while BUSY.
REQ-015 BUSY output: the generator SHALL emit one registered pixel per cycle, clear_valid=1 with the latched colour.
REQ-016 First pixel: (xmin,ymin) SHALL appear in the cycle after start was sampled.
REQ-017 Scan order is raster order: x increments fastest from xmin to xmax; then x returns to xmin and y increments, up to ymax.
REQ-018 Pixel count: exactly (xmax-xmin+1)*(ymax-ymin+1) pixels SHALL be emitted, on consecutive cycles with no gaps.
REQ-019 End-of-row and end-of-frame SHALL be detected by equality against xmax/ymax before incrementing, so bounds of 0xFFFFFFFF SHALL NOT wrap or loop.
REQ-020 Completion: done SHALL pulse high for exactly one cycle, in the cycle immediately after the last pixel. clear_valid SHALL be 0 in that cycle, and the generator SHALL return to IDLE.
REQ-021 A new start SHALL be accepted in the same cycle that done is high.
REQ-022 The arbiter SHALL be purely combinational, with zero latency.
REQ-023 Arbiter priority is clear > raster > simd; the highest-priority valid source SHALL drive pixel_x, pixel_y and pixel_color, and pixel_valid=1.
REQ-024 With no source valid, pixel_valid SHALL be 0 and pixel_x, pixel_y and pixel_color SHALL be 0.
REQ-025 Lower-priority sources SHALL be dropped without stall or backpressure when a higher source is valid; there is no ready signal.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, done=0, clear_valid=0, and all internal counters and latches to 0.
REQ-027 Reset mid-clear SHALL abort with no done pulse; the first pixel after reset release SHALL only follow a new start.
REQ-028 During reset, pixel outputs SHALL reflect only the raster and simd inputs, through the combinational arbiter.

Verification
REQ-029 Basic clear: bounds (2,3)-(4,4), color 0xFF00FF00, one-cycle start -> 6 pixels (2,3),(3,3),(4,3),(2,4),(3,4),(4,4) on consecutive cycles starting the cycle after start, then a one-cycle done.
REQ-030 Reset-default bounds: bounds all 0, start -> single pixel (0,0), done in the following cycle.
REQ-031 Empty viewport: xmin=5, xmax=4, start -> no pixel_valid, done the cycle after start.
REQ-032 Priority: raster_valid=1 at (7,8) and simd_valid=1 at (9,9) during a clear -> outputs carry clear pixels; after done -> (7,8) raster; raster_valid=0 -> (9,9) simd; all valid inputs 0 -> pixel_valid=0 and outputs 0.
REQ-033 Start ignored: second start during BUSY -> total pixel count unchanged and a single done.
REQ-034 Reset abort: rst_n low for 1 cycle mid-clear -> pixel_valid drops immediately, no done pulse, idle until the next start.
